// File: rtl/stream_mux.sv
// Registered N:1 multiplexer for valid/ready streams.
// Fixed-select or round-robin arbitration feeds a single output register stage.
module stream_mux #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumSel      = 4,
  parameter int unsigned NumSelWidth = $clog2(NumSel)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mode_i,
  input  logic [NumSelWidth-1:0]        sel_i,
  input  logic [NumSel-1:0]             valid_i,
  output logic [NumSel-1:0]             ready_o,
  input  logic [NumSel*DataWidth-1:0]   data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic [NumSelWidth-1:0]        src_o
);

  localparam logic [NumSelWidth:0] NumSelExt  = (NumSelWidth+1)'(NumSel);
  localparam logic [NumSelWidth-1:0] LastIdx  = NumSelWidth'(NumSel - 1);

  logic                   r_valid;
  logic [DataWidth-1:0]   r_data;
  logic [NumSelWidth-1:0] r_src;
  logic [NumSelWidth-1:0] r_ptr;

  logic [DataWidth-1:0]   w_data_arr [NumSel];
  logic                   w_load;
  logic                   w_fix_vld;
  logic                   w_rr_vld;
  logic [NumSelWidth-1:0] w_rr_gnt;
  logic [NumSelWidth:0]   w_sum;
  logic [NumSelWidth-1:0] w_idx;
  logic [NumSelWidth-1:0] w_gnt;
  logic                   w_gnt_vld;
  logic                   w_xfer_in;

  // Unpack the flat payload bus into one word per channel
  for (genvar k = 0; k < NumSel; k++) begin : g_unpack
    assign w_data_arr[k] = data_i[k*DataWidth +: DataWidth];
  end

  // Output stage can take a new beat when empty or draining this cycle
  assign w_load = !r_valid | ready_i;

  // Fixed-select grant; an out-of-range index never grants
  always_comb begin
    w_fix_vld = 1'b0;
    if ({1'b0, sel_i} < NumSelExt) begin
      w_fix_vld = valid_i[sel_i];
    end
  end

  // Round-robin scan starting at the pointer, wrapping at NumSel-1
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NumSel; i++) begin
      w_sum = {1'b0, r_ptr} + (NumSelWidth+1)'(i);
      if (w_sum >= NumSelExt) begin
        w_sum = w_sum - NumSelExt;
      end
      w_idx = w_sum[NumSelWidth-1:0];
      if (!w_rr_vld && valid_i[w_idx]) begin
        w_rr_vld = 1'b1;
        w_rr_gnt = w_idx;
      end
    end
  end

  assign w_gnt     = mode_i ? w_rr_gnt : sel_i;
  assign w_gnt_vld = mode_i ? w_rr_vld : w_fix_vld;
  // Nothing is consumed upstream while reset is asserted
  assign w_xfer_in = w_load & w_gnt_vld & !rst_i;

  // One-hot ready towards the granted channel (comb path from ready_i)
  always_comb begin
    ready_o = '0;
    for (int k = 0; k < NumSel; k++) begin
      ready_o[k] = w_xfer_in & (w_gnt == NumSelWidth'(k));
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_data <= w_data_arr[w_gnt];
          r_src  <= w_gnt;
        end
      end
      if (w_xfer_in && mode_i) begin
        r_ptr <= (w_gnt == LastIdx) ? '0 : w_gnt + NumSelWidth'(1);
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign src_o   = r_src;

endmodule

// File: tb/tb_stream_mux.sv
// Directed, table-driven bench for stream_mux (4-channel) plus a 3-channel
// instance for out-of-range select and non-power-of-two wrap.
module tb_stream_mux;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  valid;
  logic [3:0]  ready_o;
  logic [127:0] data;
  logic        valid_o;
  logic        ready;
  logic [31:0] data_o;
  logic [1:0]  src_o;

  logic        rst3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  valid3;
  logic [2:0]  ready3_o;
  logic [95:0] data3;
  logic        valid3_o;
  logic        ready3;
  logic [31:0] data3_o;
  logic [1:0]  src3_o;

  int passed = 0;
  int total  = 0;

  stream_mux #(.DataWidth(32), .NumSel(4)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .valid_i(valid), .ready_o(ready_o), .data_i(data),
    .valid_o(valid_o), .ready_i(ready), .data_o(data_o), .src_o(src_o)
  );

  stream_mux #(.DataWidth(32), .NumSel(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .mode_i(mode3), .sel_i(sel3),
    .valid_i(valid3), .ready_o(ready3_o), .data_i(data3),
    .valid_o(valid3_o), .ready_i(ready3), .data_o(data3_o), .src_o(src3_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_vo;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic rd, input logic [3:0] er,
                     input logic evo, input logic [1:0] es, input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.rdy = rd;
    t.exp_ready = er; t.exp_vo = evo; t.exp_src = es; t.exp_data = ed;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; valid = '0; ready = 1'b1;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; valid3 = '0; ready3 = 1'b1;
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'hA0 + 32'(k);
    for (int k = 0; k < 3; k++) data3[k*32 +: 32] = 32'hB0 + 32'(k);

    //   rst mode sel  valid    rdy  exp_ready vo src data
    add(1, 0, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0);   // reset
    add(1, 0, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0);
    add(0, 0, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0);   // idle after reset
    add(0, 0, 2'd2, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'hA2);  // fixed sel 2
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 32'hA0);  // rr fairness x8
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 32'hA1);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'hA2);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 32'hA3);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 32'hA0);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 32'hA1);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'hA2);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 32'hA3);
    add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 32'hA1);  // rr skip 1,3,1
    add(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 32'hA3);
    add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 32'hA1);
    for (int i = 0; i < 5; i++)                               // stall 5 cycles
      add(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd1, 32'hA1);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'hA2);  // release, ptr=2
    add(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd2, 32'hA2);  // stall again
    add(1, 1, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0, 32'h0);   // reset mid-stall
    add(0, 1, 2'd0, 4'b1001, 0, 4'b0001, 1, 2'd0, 32'hA0);  // ptr back to 0
    add(0, 0, 2'd1, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'hA0);  // no grant, data holds
    add(0, 0, 2'd3, 4'b1000, 1, 4'b1000, 1, 2'd3, 32'hA3);  // fixed sel 3
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 32'hA1);  // ptr held at 1 in fixed

    foreach (vq[i]) begin
      rst = vq[i].rst; mode = vq[i].mode; sel = vq[i].sel;
      valid = vq[i].valid; ready = vq[i].rdy;
      #1;
      chk("ready_o", i, 32'(ready_o), 32'(vq[i].exp_ready));
      @(posedge clk); #1;
      chk("valid_o", i, 32'(valid_o), 32'(vq[i].exp_vo));
      chk("src_o",   i, 32'(src_o),   32'(vq[i].exp_src));
      chk("data_o",  i, data_o,       vq[i].exp_data);
    end

    // 3-channel instance: out-of-range select and wrap at NumSel-1
    rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; ready3 = 1'b1;
    #1;
    chk("n3_oor_ready", 0, 32'(ready3_o), 32'h0);
    @(posedge clk); #1;
    chk("n3_oor_valid", 0, 32'(valid3_o), 32'h0);
    sel3 = 2'd2;
    #1;
    chk("n3_sel2_ready", 1, 32'(ready3_o), 32'b100);
    @(posedge clk); #1;
    chk("n3_sel2_valid", 1, 32'(valid3_o), 32'h1);
    chk("n3_sel2_data",  1, data3_o, 32'hB2);
    sel3 = 2'd3;
    @(posedge clk); #1;
    chk("n3_oor_drain", 2, 32'(valid3_o), 32'h0);
    chk("n3_oor_hold",  2, data3_o, 32'hB2);
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("n3_rr_src", 3 + i, 32'(src3_o), 32'(i % 3));
      chk("n3_rr_data", 3 + i, data3_o, 32'hB0 + 32'(i % 3));
    end
    // Reset while holding a beat drops it
    ready3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("n3_rst_ready", 7, 32'(ready3_o), 32'h0);
    @(posedge clk); #1;
    chk("n3_rst_valid", 7, 32'(valid3_o), 32'h0);
    chk("n3_rst_src",   7, 32'(src3_o), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
